decode_stage: RTL

Registered, parametrised instruction-decode stage for the pipelined RISC-V core, between the IF/ID fetch buffer and the issue/register-read stage. Splits an instruction into fields and produces an XLEN-wide immediate, covering I/S/B/U/J and CSR forms. Also produces a one-hot format class and a zero-extended CSR `zimm`. Holds results in an output register plus a one-entry skid buffer, with valid/ready handshakes on both sides and a pipeline flush.

---
 rtl/decode_pkg.sv | 49 ++++
 rtl/decode_stage_imm_gen.sv | 67 ++++++
 rtl/decode_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, one-hot format classes and the decoded
// field bundle shared by the decode stage and its immediate generator.
package decode_pkg;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_OP32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // One-hot format class. LUI/AUIPC/JAL/SYSTEM get their own classes so
  // issue can steer them without re-decoding; their immediates still use
  // the U/U/J/I layouts respectively.
  typedef enum logic [10:0] {
    CLS_I     = 11'b000_0000_0001,
    CLS_S     = 11'b000_0000_0010,
    CLS_B     = 11'b000_0000_0100,
    CLS_U     = 11'b000_0000_1000,
    CLS_J     = 11'b000_0001_0000,
    CLS_R     = 11'b000_0010_0000,
    CLS_LUI   = 11'b000_0100_0000,
    CLS_AUIPC = 11'b000_1000_0000,
    CLS_JAL   = 11'b001_0000_0000,
    CLS_CSR   = 11'b010_0000_0000,
    CLS_NONE  = 11'b100_0000_0000
  } cls_e;

  // XLEN-independent part of a decoded instruction
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7_30;
    logic       func7_25;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    cls_e       cls;
    logic       illegal;
  } fields_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational class decode and immediate generation.
// Optional feature macro: DECODE_ILLEGAL_EN enables the illegal flag;
// without it the flag is constant 0.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output cls_e            cls,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] zimm,
  output logic            illegal
);

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;
  logic signed [31:0] sel_imm;

  assign imm_i = 32'($signed(instr[31:20]));
  assign imm_s = 32'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = $signed({instr[31:12], 12'b0});
  assign imm_j = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  // Pick class and immediate layout from the major opcode
  always_comb begin
    cls     = CLS_NONE;
    sel_imm = '0;
    case (instr[6:2])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin cls = CLS_I;     sel_imm = imm_i; end
      OPC_SYSTEM:                     begin cls = CLS_CSR;   sel_imm = imm_i; end
      OPC_LUI:                        begin cls = CLS_LUI;   sel_imm = imm_u; end
      OPC_AUIPC:                      begin cls = CLS_AUIPC; sel_imm = imm_u; end
      OPC_JAL:                        begin cls = CLS_JAL;   sel_imm = imm_j; end
      OPC_BRANCH:                     begin cls = CLS_B;     sel_imm = imm_b; end
      OPC_STORE:                      begin cls = CLS_S;     sel_imm = imm_s; end
      OPC_OP:                         cls = CLS_R;
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          cls     = CLS_I;
          sel_imm = imm_i;
        end
      end
      OPC_OP32: begin
        if (XLEN == 64) cls = CLS_R;
      end
      default: ;
    endcase
  end

  // 32-bit immediate sign-extends to the datapath width
  assign imm  = XLEN'(sel_imm);
  assign zimm = XLEN'(instr[19:15]);

`ifdef DECODE_ILLEGAL_EN
  assign illegal = (instr[1:0] != 2'b11) || (cls == CLS_NONE);
`else
  logic unused_lsb;
  assign unused_lsb = ^instr[1:0];
  assign illegal    = 1'b0;
`endif

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with an output register and a one-entry
// skid buffer so in_ready comes straight from a flop.
// Optional feature macro: DECODE_ILLEGAL_EN (illegal-encoding flag).
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic            out_func7_30,
  output logic            out_func7_25,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_zimm,
  output logic [10:0]     out_class,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] zimm;
    fields_t         f;
  } entry_t;

  localparam entry_t ENTRY_RST = '{
    pc: '0, imm: '0, zimm: '0,
    f: '{opcode: '0, func3: '0, func7_30: 1'b0, func7_25: 1'b0,
         rs1: '0, rs2: '0, rd: '0, cls: CLS_NONE, illegal: 1'b0}
  };

  cls_e            dec_cls;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_zimm;
  logic            dec_illegal;
  entry_t          dec_entry;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_vld_q, out_vld_d;
  logic   skid_vld_q, skid_vld_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;
  logic   consume;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (in_instr),
    .cls     (dec_cls),
    .imm     (dec_imm),
    .zimm    (dec_zimm),
    .illegal (dec_illegal)
  );

  // Assemble the decoded bundle for the incoming instruction
  always_comb begin
    dec_entry            = ENTRY_RST;
    dec_entry.pc         = in_pc;
    dec_entry.imm        = dec_imm;
    dec_entry.zimm       = dec_zimm;
    dec_entry.f.opcode   = in_instr[6:0];
    dec_entry.f.func3    = in_instr[14:12];
    dec_entry.f.func7_30 = in_instr[30];
    dec_entry.f.func7_25 = in_instr[25];
    dec_entry.f.rs1      = in_instr[19:15];
    dec_entry.f.rs2      = in_instr[24:20];
    dec_entry.f.rd       = in_instr[11:7];
    dec_entry.f.cls      = dec_cls;
    dec_entry.f.illegal  = dec_illegal;
  end

  assign accept  = in_valid && in_ready_q;
  assign consume = out_vld_q && out_ready;

  // OUT/SKID transfer rules; flush overrides everything including an accept
  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (consume || !out_vld_q) begin
      // OUT frees up: the older SKID entry goes first to keep FIFO order
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = dec_entry;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec_entry;
      skid_vld_d = 1'b1;
    end
    in_ready_d = !skid_vld_d;
  end

  // Storage registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= ENTRY_RST;
      skid_q     <= ENTRY_RST;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_vld_q;
  assign out_pc       = out_q.pc;
  assign out_imm      = out_q.imm;
  assign out_zimm     = out_q.zimm;
  assign out_opcode   = out_q.f.opcode;
  assign out_func3    = out_q.f.func3;
  assign out_func7_30 = out_q.f.func7_30;
  assign out_func7_25 = out_q.f.func7_25;
  assign out_rs1      = out_q.f.rs1;
  assign out_rs2      = out_q.f.rs2;
  assign out_rd       = out_q.f.rd;
  assign out_class    = out_q.f.cls;
  assign out_illegal  = out_q.f.illegal;

endmodule
